// File: rtl/pfc_pkg.sv
// Shared constants for the parametrised frame counter: FSM state encoding and TX/RX mode values.
// State values are fixed so other blocks can decode them.
package pfc_pkg;

    localparam logic [1:0] PFC_IDLE = 2'd0;
    localparam logic [1:0] PFC_RUN  = 2'd1;
    localparam logic [1:0] PFC_LAST = 2'd2;

    localparam logic PFC_MODE_RX = 1'b0;
    localparam logic PFC_MODE_TX = 1'b1;

endpackage

// File: rtl/param_frame_counter.sv
// Frame counter: counts frame-done strobes up to a latched terminal index, flags last frame / done.
// All outputs registered (visible 1 cycle after the causing strobe); no backpressure, strobes always accepted.
module param_frame_counter
    import pfc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             i_pfc_clk,
    input  logic             i_pfc_rst,
    input  logic             i_pfc_start,
    input  logic [CNT_W-1:0] i_pfc_no_frms,
    input  logic             i_pfc_mode,
    input  logic             i_pfc_frm_done,
    input  logic             i_pfc_abort,
    input  logic             i_pfc_auto_reload,
    output logic [CNT_W-1:0] o_pfc_frm_idx,
    output logic             o_pfc_last_frame,
    output logic             o_pfc_done,
    output logic             o_pfc_busy,
    output logic             o_pfc_err
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] term_q, term_d;
    logic             done_d, err_d;
    logic [CNT_W-1:0] idx_inc;
    logic [CNT_W-1:0] start_term;
    logic             start_bad;

    assign idx_inc    = idx_q + 1'b1;
    // TX runs N frames, RX runs N+1; N-1 wraps in CNT_W bits but N=0 TX is rejected anyway.
    assign start_term = (i_pfc_mode == PFC_MODE_TX) ? (i_pfc_no_frms - 1'b1) : i_pfc_no_frms;
    assign start_bad  = (i_pfc_mode == PFC_MODE_TX) && (i_pfc_no_frms == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        term_d  = term_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            PFC_IDLE: begin
                if (!i_pfc_abort && i_pfc_start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        term_d  = start_term;
                        idx_d   = '0;
                        state_d = (start_term == '0) ? PFC_LAST : PFC_RUN;
                    end
                end
            end
            PFC_RUN: begin
                if (i_pfc_abort) begin
                    state_d = PFC_IDLE;
                    idx_d   = '0;
                end else if (i_pfc_frm_done) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == term_q) ? PFC_LAST : PFC_RUN;
                end
            end
            PFC_LAST: begin
                if (i_pfc_abort) begin
                    state_d = PFC_IDLE;
                    idx_d   = '0;
                end else if (i_pfc_frm_done) begin
                    done_d = 1'b1;
                    idx_d  = '0;
                    if (i_pfc_auto_reload) begin
                        state_d = (term_q == '0) ? PFC_LAST : PFC_RUN;
                    end else begin
                        state_d = PFC_IDLE;
                    end
                end
            end
            default: begin
                state_d = PFC_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_pfc_clk) begin
        if (i_pfc_rst) begin
            state_q          <= PFC_IDLE;
            idx_q            <= '0;
            term_q           <= '0;
            o_pfc_last_frame <= 1'b0;
            o_pfc_done       <= 1'b0;
            o_pfc_busy       <= 1'b0;
            o_pfc_err        <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            term_q           <= term_d;
            o_pfc_last_frame <= (state_d == PFC_LAST);
            o_pfc_done       <= done_d;
            o_pfc_busy       <= (state_d != PFC_IDLE);
            o_pfc_err        <= err_d;
        end
    end

    assign o_pfc_frm_idx = idx_q;

endmodule

// File: tb/tb_param_frame_counter.sv
// Directed bench for param_frame_counter with hand-computed expectations.
module tb_param_frame_counter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] no_frms;
    logic             mode;
    logic             frm_done;
    logic             abort;
    logic             auto_reload;
    logic [CNT_W-1:0] frm_idx;
    logic             last_frame;
    logic             done;
    logic             busy;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;

    param_frame_counter #(.CNT_W(CNT_W)) dut (
        .i_pfc_clk         (clk),
        .i_pfc_rst         (rst),
        .i_pfc_start       (start),
        .i_pfc_no_frms     (no_frms),
        .i_pfc_mode        (mode),
        .i_pfc_frm_done    (frm_done),
        .i_pfc_abort       (abort),
        .i_pfc_auto_reload (auto_reload),
        .o_pfc_frm_idx     (frm_idx),
        .o_pfc_last_frame  (last_frame),
        .o_pfc_done        (done),
        .o_pfc_busy        (busy),
        .o_pfc_err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle 1 time unit so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic m);
        start = 1'b1; no_frms = n; mode = m;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe();
        frm_done = 1'b1;
        tick();
        frm_done = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int idx, input bit lst, input bit dn, input bit bsy);
        chk({tag, ".idx"},  32'(frm_idx),    32'(idx));
        chk({tag, ".last"}, 32'(last_frame), 32'(lst));
        chk({tag, ".done"}, 32'(done),       32'(dn));
        chk({tag, ".busy"}, 32'(busy),       32'(bsy));
    endtask

    int  rx_idx  [4] = '{1, 2, 3, 0};
    bit  rx_last [4] = '{0, 0, 1, 0};
    bit  rx_done [4] = '{0, 0, 0, 1};

    initial begin
        rst = 1'b1; start = 1'b0; no_frms = '0; mode = 1'b0;
        frm_done = 1'b0; abort = 1'b0; auto_reload = 1'b0;
        #1;
        idle(2);
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.err", 32'(err), 0);
        rst = 1'b0;
        idle(1);

        // RX, N=3: four frames, strobes 5 cycles apart
        do_start(8'd3, 1'b0);
        chk_out("rx3.start", 0, 0, 0, 1);
        for (int s = 0; s < 4; s++) begin
            strobe();
            chk_out($sformatf("rx3.s%0d", s + 1), rx_idx[s], rx_last[s], rx_done[s], (s < 3));
            tick();
            chk($sformatf("rx3.s%0d.done_fall", s + 1), 32'(done), 0);
            idle(3);
        end

        // TX, N=3: three frames, last frame at idx 2
        do_start(8'd3, 1'b1);
        chk_out("tx3.start", 0, 0, 0, 1);
        strobe(); chk_out("tx3.s1", 1, 0, 0, 1);
        strobe(); chk_out("tx3.s2", 2, 1, 0, 1);
        strobe(); chk_out("tx3.s3", 0, 0, 1, 0);
        idle(2);

        // TX, N=0: rejected
        do_start(8'd0, 1'b1);
        chk("tx0.err", 32'(err), 1);
        chk("tx0.busy", 32'(busy), 0);
        tick();
        chk("tx0.err_fall", 32'(err), 0);
        chk("tx0.busy2", 32'(busy), 0);

        // TX, N=1: straight into LAST
        do_start(8'd1, 1'b1);
        chk_out("tx1.start", 0, 1, 0, 1);
        chk("tx1.err", 32'(err), 0);
        strobe(); chk_out("tx1.s1", 0, 0, 1, 0);
        idle(2);

        // RX, N=5, abort after second strobe, then RX N=1
        do_start(8'd5, 1'b0);
        strobe(); strobe();
        chk_out("rx5.s2", 2, 0, 0, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk_out("rx5.abort", 0, 0, 0, 0);
        tick();
        chk("rx5.no_done", 32'(done), 0);
        do_start(8'd1, 1'b0);
        chk_out("rx1.start", 0, 0, 0, 1);
        strobe(); chk_out("rx1.s1", 1, 1, 0, 1);
        strobe(); chk_out("rx1.s2", 0, 0, 1, 0);
        idle(2);

        // Abort together with start in IDLE: abort wins
        abort = 1'b1; do_start(8'd4, 1'b0); abort = 1'b0;
        chk_out("idle_abort_start", 0, 0, 0, 0);

        // Auto-reload, TX, N=2: done after strobes 2, 4, 6, busy held
        auto_reload = 1'b1;
        do_start(8'd2, 1'b1);
        chk_out("ar.start", 0, 0, 0, 1);
        for (int s = 1; s <= 6; s++) begin
            strobe();
            chk_out($sformatf("ar.s%0d", s), (s % 2), (s % 2), ((s % 2) == 0), 1);
        end
        auto_reload = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        chk_out("ar.abort", 0, 0, 0, 0);

        // LAST->IDLE with start in same cycle: start ignored
        do_start(8'd0, 1'b0);
        chk_out("rx0.start", 0, 1, 0, 1);
        start = 1'b1; no_frms = 8'd3; frm_done = 1'b1;
        tick();
        start = 1'b0; frm_done = 1'b0;
        chk_out("rx0.done_start", 0, 0, 1, 0);
        tick();
        chk_out("rx0.after", 0, 0, 0, 0);

        // RX, N=255: 256 frames, full index range without wrap
        do_start(8'd255, 1'b0);
        for (int s = 1; s <= 254; s++) strobe();
        chk_out("rx255.s254", 254, 0, 0, 1);
        strobe(); chk_out("rx255.s255", 255, 1, 0, 1);
        strobe(); chk_out("rx255.s256", 0, 0, 1, 0);

        // Start while busy ignored (no reload of T), then reset mid-RUN at idx 4
        do_start(8'd7, 1'b0);
        strobe(); strobe();
        do_start(8'd1, 1'b1);
        chk_out("busy_start", 2, 0, 0, 1);
        chk("busy_start.err", 32'(err), 0);
        strobe(); strobe();
        chk_out("run.idx4", 4, 0, 0, 1);
        rst = 1'b1; frm_done = 1'b1;
        tick();
        rst = 1'b0; frm_done = 1'b0;
        chk_out("rst_run", 0, 0, 0, 0);
        chk("rst_run.err", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
